rotr_pipe: RTL and testbench

ROTR_PIPE -- requirements
Module: rotr_pipe

---
 rtl/rotr_pkg.sv | 19 +
 rtl/rotr_stage.sv | 50 +++++
 rtl/rotr_pipe.sv | 65 ++++++
 tb/tb_rotr_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotr_pkg.sv
// rotr_pkg: operation encodings and log2 helper shared by the rotate/shift pipeline
package rotr_pkg;

    typedef enum logic [1:0] {
        ROTR = 2'd0,
        ROTL = 2'd1,
        SHR  = 2'd2,
        SHL  = 2'd3
    } mode_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rotr_stage.sv
// rotr_stage: one registered level, conditionally moving the word by 2**K
module rotr_stage
    import rotr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int K = 0,
    localparam int LEVELS = log2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_amt,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [LEVELS-1:0] out_amt,
    output logic [1:0]        out_mode,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] nd;

    always_comb
        nd = !in_amt[K]        ? in_data :
             in_mode == ROTR   ? {in_data[S-1:0], in_data[WIDTH-1:S]} :
             in_mode == ROTL   ? {in_data[WIDTH-S-1:0], in_data[WIDTH-1:WIDTH-S]} :
             in_mode == SHR    ? in_data >> S :
                                 in_data << S;

    // only valid is reset; payload is don't-care while invalid
    always_ff @(posedge clk) begin
        if (rst)
            out_valid <= 1'b0;
        else if (ld)
            out_valid <= in_valid;
        if (ld) begin
            out_data <= nd;
            out_amt  <= in_amt;
            out_mode <= in_mode;
            out_tag  <= in_tag;
        end
    end

endmodule

// File: rtl/rotr_pipe.sv
// rotr_pipe: LEVELS-deep elastic rotate/shift pipeline with valid/ready on both ports
module rotr_pipe
    import rotr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int LEVELS = log2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_amt,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);

    // index k is the input of stage k; index LEVELS is the pipeline output
    logic [LEVELS:0]   v;
    logic [LEVELS:0]   ld;
    logic [WIDTH-1:0]  d [LEVELS+1];
    logic [LEVELS-1:0] a [LEVELS+1];
    logic [1:0]        m [LEVELS+1];
    logic [TAG_W-1:0]  t [LEVELS+1];
    logic              unused_tail;

    assign v[0] = in_valid;
    assign d[0] = in_data;
    assign a[0] = in_amt;
    assign m[0] = in_mode;
    assign t[0] = in_tag;
    assign ld[LEVELS] = out_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        // a stage may load when empty or when its successor is taking its word
        assign ld[k] = !v[k+1] || ld[k+1];
        rotr_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .K(k)) u_stage (
            .clk(clk),
            .rst(rst),
            .ld(ld[k]),
            .in_valid(v[k]),
            .in_data(d[k]),
            .in_amt(a[k]),
            .in_mode(m[k]),
            .in_tag(t[k]),
            .out_valid(v[k+1]),
            .out_data(d[k+1]),
            .out_amt(a[k+1]),
            .out_mode(m[k+1]),
            .out_tag(t[k+1])
        );
    end

    assign in_ready    = ld[0];
    assign out_valid   = v[LEVELS];
    assign out_data    = d[LEVELS];
    assign out_tag     = t[LEVELS];
    assign unused_tail = ^{a[LEVELS], m[LEVELS]};

endmodule

// File: tb/tb_rotr_pipe.sv
// tb_rotr_pipe: directed and randomized checks of rotr_pipe against a queue-based model
module tb_rotr_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    rotr_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_amt(in_amt),
        .in_mode(in_mode),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    bit          chk_lat = 0;
    bit          stalled = 0;
    bit          acc = 0;
    logic [35:0] held;
    logic [31:0] last_out;
    logic [31:0] qd[$];
    logic [3:0]  qt[$];
    int          qc[$];

    function automatic logic [31:0] model(logic [31:0] x, int sh, logic [1:0] md);
        logic [63:0] dd;
        dd = {x, x};
        case (md)
            2'd0:    return 32'(dd >> sh);
            2'd1:    return 32'((dd << sh) >> 32);
            2'd2:    return x >> sh;
            default: return x << sh;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: evaluate handshakes mid-cycle, then advance to just after the edge
    task automatic tick();
        @(negedge clk);
        if (stalled) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_word", 64'({out_data, out_tag}), 64'(held));
        end
        if (out_valid && out_ready) begin
            if (qd.size() == 0) chk("spurious", 64'(out_valid), 64'd0);
            else begin
                chk("data", 64'(out_data), 64'(qd.pop_front()));
                chk("tag", 64'(out_tag), 64'(qt.pop_front()));
                if (chk_lat) chk("latency", 64'(cyc - qc[0]), 64'd5);
                void'(qc.pop_front());
            end
            last_out = out_data;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            qd.push_back(model(in_data, int'(in_amt), in_mode));
            qt.push_back(in_tag);
            qc.push_back(cyc);
        end
        stalled = out_valid && !out_ready;
        held = {out_data, out_tag};
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 0;
        out_ready = 1;
        while ((qd.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 100), 64'd1);
    endtask

    task automatic send(input logic [31:0] x, input logic [4:0] sh, input logic [1:0] md);
        out_ready = 1;
        in_valid = 1;
        in_data = x;
        in_amt = sh;
        in_mode = md;
        in_tag = 4'(md);
        tick();
        drain();
    endtask

    initial begin
        int ntag;
        int n;
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        in_data = 0;
        in_amt = 0;
        in_mode = 0;
        in_tag = 0;
        repeat (2) tick();
        rst = 0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        chk_lat = 1;
        send(32'h00000001, 5'd1, 2'd0);
        chk("rotr_1", 64'(last_out), 64'h80000000);
        send(32'h80000001, 5'd4, 2'd1);
        chk("rotl_4", 64'(last_out), 64'h00000018);
        send(32'hF0000000, 5'd28, 2'd2);
        chk("shr_28", 64'(last_out), 64'h0000000F);
        send(32'hFFFFFFFF, 5'd31, 2'd3);
        chk("shl_31", 64'(last_out), 64'h80000000);
        for (int md = 0; md < 4; md++) begin
            send(32'hDEADBEEF, 5'd0, 2'(md));
            chk("amt0", 64'(last_out), 64'hDEADBEEF);
        end
        send(32'h12345678, 5'd31, 2'd0);
        chk("rotr_31", 64'(last_out), 64'h2468ACF0);
        chk_lat = 0;

        // fill with the output blocked, then release
        out_ready = 0;
        ntag = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            in_data = $urandom;
            in_amt = 5'($urandom);
            in_mode = 2'($urandom);
            in_tag = 4'(ntag);
            tick();
            if (acc) ntag++;
        end
        chk("fill_count", 64'(ntag), 64'd5);
        chk("fill_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
        n = 0;
        while (ntag < 8 && n < 50) begin
            in_data = $urandom;
            in_amt = 5'($urandom);
            in_mode = 2'($urandom);
            in_tag = 4'(ntag);
            tick();
            if (acc) ntag++;
            n++;
        end
        chk("fill_rest", 64'(ntag), 64'd8);
        drain();
        chk("fill_last_tag", 64'(qt.size()), 64'd0);

        // random traffic with random back-pressure
        ntag = 0;
        n = 0;
        while (ntag < 1000 && n < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            in_amt = 5'($urandom);
            in_mode = 2'($urandom);
            in_tag = 4'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            tick();
            if (acc) ntag++;
            n++;
        end
        chk("random_count", 64'(ntag), 64'd1000);
        drain();

        // reset with words in flight
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data = $urandom;
            in_amt = 5'($urandom);
            in_mode = 2'($urandom);
            in_tag = 4'(i);
            tick();
        end
        in_valid = 0;
        chk("inflight", 64'(qd.size()), 64'd3);
        rst = 1;
        tick();
        rst = 0;
        qd.delete();
        qt.delete();
        qc.delete();
        stalled = 0;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1;
        repeat (12) begin
            tick();
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        send(32'hA5A5A5A5, 5'd8, 2'd1);
        chk("post_rst", 64'(last_out), 64'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
